pulse_peak_pick: RTL and testbench

Pulse-height picker that sits directly downstream of the trapezoidal shaper and consumes its final shaped output. It detects each shaped pulse with a threshold comparator plus hysteresis, and tracks the maximum and its time-from-trigger. At pulse end it either emits one peak record or flags pileup. It then enforces a programmable dead time. It suppresses triggers during the shaper's post-reset settling window and feeds the MCA/histogram stage.

---
 rtl/pulse_peak_pick.sv | 182 ++++++++++++++++++
 tb/tb_pulse_peak_pick.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_peak_pick.sv
// pulse_peak_pick: threshold/hysteresis pulse detector with peak capture,
// pileup rejection, dead time and post-reset arming window.
module pulse_peak_pick #(
  parameter int W         = 16,
  parameter int THR       = 200,
  parameter int HYST      = 20,
  parameter int MAX_WIDTH = 1023,
  parameter int HOLDOFF   = 64,
  parameter int ARM_DELAY = 406
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] inp,
  output logic signed [W-1:0] peak,
  output logic [11:0]         peak_time,
  output logic                peak_valid,
  output logic                pileup,
  output logic                busy,
  output logic [1:0]          state,
  output logic [15:0]         evt_count,
  output logic [15:0]         pu_count
);

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } st_t;

  localparam int W1 = W + 1;
  localparam logic signed [W:0] THR_X = W1'(THR);
  localparam logic signed [W:0] END_X = W1'(THR - HYST);
  localparam logic signed [W:0] HYS_X = W1'(HYST);
  localparam logic [15:0] ARM_LAST = 16'(ARM_DELAY - 1);
  localparam logic [15:0] HLD_LAST = 16'(HOLDOFF - 1);
  localparam logic [11:0] WID_MAX  = 12'(MAX_WIDTH);

  st_t                cur, nxt;
  logic [15:0]        cnt, cnt_n;
  logic signed [W-1:0] mx, mx_n;
  logic signed [W-1:0] vl, vl_n;
  logic [11:0]        tpk, tpk_n;
  logic [11:0]        width, width_n;
  logic               fall, fall_n;
  logic               pu, pu_n;
  logic signed [W-1:0] peak_n;
  logic [11:0]        pt_n;
  logic               pv_n, pls_n;
  logic [15:0]        ec_n, pc_n;

  // Margins are formed one bit wider so they cannot wrap
  logic signed [W:0]  x, mxx, mx_lo, vl_hi;
  logic [11:0]        w_inc;

  assign x     = W1'(inp);
  assign mxx   = W1'(mx);
  assign mx_lo = mxx - HYS_X;
  assign vl_hi = W1'(vl) + HYS_X;
  assign w_inc = (width == 12'hFFF) ? width : width + 12'd1;

  assign state = cur;
  assign busy  = (cur != IDLE);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    nxt     = cur;
    cnt_n   = cnt;
    mx_n    = mx;
    vl_n    = vl;
    tpk_n   = tpk;
    width_n = width;
    fall_n  = fall;
    pu_n    = pu;
    peak_n  = peak;
    pt_n    = peak_time;
    pv_n    = 1'b0;
    pls_n   = 1'b0;
    ec_n    = evt_count;
    pc_n    = pu_count;
    unique case (cur)
      ARM: begin
        if (cnt == ARM_LAST) begin
          nxt   = IDLE;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      IDLE: begin
        if (x > THR_X) begin
          nxt     = PULSE;
          mx_n    = inp;
          vl_n    = inp;
          tpk_n   = '0;
          width_n = 12'd1;
          fall_n  = 1'b0;
          pu_n    = 1'b0;
        end
      end
      PULSE: begin
        width_n = w_inc;
        if (x > mxx) begin
          mx_n  = inp;
          tpk_n = width;
        end
        // Valley restarts at the sample that first confirms the fall
        if (fall) begin
          if (x >= vl_hi) pu_n = 1'b1;
          if (x < W1'(vl)) vl_n = inp;
        end else if (x <= mx_lo) begin
          fall_n = 1'b1;
          vl_n   = inp;
        end
        if (x < END_X) begin
          nxt   = HOLD;
          cnt_n = '0;
          if (pu_n) begin
            pls_n = 1'b1;
            pc_n  = sat_inc(pu_count);
          end else begin
            pv_n   = 1'b1;
            peak_n = mx_n;
            pt_n   = tpk_n;
            ec_n   = sat_inc(evt_count);
          end
        end else if (w_inc >= WID_MAX) begin
          nxt   = HOLD;
          cnt_n = '0;
          pls_n = 1'b1;
          pc_n  = sat_inc(pu_count);
        end
      end
      HOLD: begin
        if (cnt == HLD_LAST) begin
          nxt   = IDLE;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur        <= ARM;
      cnt        <= '0;
      mx         <= '0;
      vl         <= '0;
      tpk        <= '0;
      width      <= '0;
      fall       <= 1'b0;
      pu         <= 1'b0;
      peak       <= '0;
      peak_time  <= '0;
      peak_valid <= 1'b0;
      pileup     <= 1'b0;
      evt_count  <= '0;
      pu_count   <= '0;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_n;
      mx         <= mx_n;
      vl         <= vl_n;
      tpk        <= tpk_n;
      width      <= width_n;
      fall       <= fall_n;
      pu         <= pu_n;
      peak       <= peak_n;
      peak_time  <= pt_n;
      peak_valid <= pv_n;
      pileup     <= pls_n;
      evt_count  <= ec_n;
      pu_count   <= pc_n;
    end
  end

endmodule

// File: tb/tb_pulse_peak_pick.sv
// tb_pulse_peak_pick: directed and random sample streams compared cycle by
// cycle with a pulse-segment reference model.
module tb_pulse_peak_pick;

  localparam int ARM_D  = 8;
  localparam int THR    = 200;
  localparam int HYST   = 20;
  localparam int MAX_W  = 50;
  localparam int HOLD_D = 10;
  localparam int MAXN   = 1024;

  logic               clk;
  logic               rst;
  logic signed [15:0] inp;
  logic signed [15:0] peak;
  logic [11:0]        peak_time;
  logic               peak_valid;
  logic               pileup;
  logic               busy;
  logic [1:0]         state;
  logic [15:0]        evt_count;
  logic [15:0]        pu_count;

  pulse_peak_pick #(
    .W(16), .THR(THR), .HYST(HYST), .MAX_WIDTH(MAX_W),
    .HOLDOFF(HOLD_D), .ARM_DELAY(ARM_D)
  ) dut (
    .clk(clk), .rst(rst), .inp(inp),
    .peak(peak), .peak_time(peak_time),
    .peak_valid(peak_valid), .pileup(pileup),
    .busy(busy), .state(state),
    .evt_count(evt_count), .pu_count(pu_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;

  int s[$];
  int e_st[MAXN], e_pv[MAXN], e_pu[MAXN];
  int e_pk[MAXN], e_pt[MAXN], e_ec[MAXN], e_pc[MAXN];

  task automatic chk(input string tag, input logic signed [31:0] o,
                     input logic signed [31:0] e);
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, o, e);
  endtask

  task automatic add(input int v, input int c = 1);
    for (int k = 0; k < c; k++) s.push_back(v);
  endtask

  // Walk the stream pulse by pulse; record per-cycle state and events
  task automatic build_model();
    int n, i, j, mx, tp, w, vl, pk, pt, ec, pc;
    int ev[MAXN], pkv[MAXN], ptv[MAXN], stb[MAXN];
    bit fl, pf, done;
    n = s.size();
    for (int k = 0; k < MAXN; k++) begin
      ev[k] = 0; pkv[k] = 0; ptv[k] = 0; stb[k] = 1;
    end
    for (int k = 0; k < ARM_D && k < n; k++) stb[k] = 0;
    i = ARM_D;
    while (i < n) begin
      if (s[i] <= THR) begin
        i++;
      end else begin
        mx = s[i]; tp = 0; w = 1; fl = 0; pf = 0; vl = s[i];
        done = 0; j = i;
        while (!done && j + 1 < n) begin
          j++;
          stb[j] = 2;
          if (s[j] > mx) begin mx = s[j]; tp = w; end
          w++;
          if (fl) begin
            if (s[j] >= vl + HYST) pf = 1;
            if (s[j] < vl) vl = s[j];
          end else if (s[j] <= mx - HYST) begin
            fl = 1; vl = s[j];
          end
          if (s[j] < THR - HYST) begin
            done = 1; ev[j] = pf ? 2 : 1; pkv[j] = mx; ptv[j] = tp;
          end else if (w == MAX_W) begin
            done = 1; ev[j] = 2;
          end
        end
        if (done) begin
          for (int k = j + 1; k <= j + HOLD_D && k < n; k++) stb[k] = 3;
          i = j + HOLD_D + 1;
        end else begin
          i = n;
        end
      end
    end
    pk = 0; pt = 0; ec = 0; pc = 0;
    for (int k = 0; k < n; k++) begin
      if (ev[k] == 1) begin pk = pkv[k]; pt = ptv[k]; ec++; end
      if (ev[k] == 2) pc++;
      e_pv[k] = (ev[k] == 1) ? 1 : 0;
      e_pu[k] = (ev[k] == 2) ? 1 : 0;
      e_pk[k] = pk; e_pt[k] = pt; e_ec[k] = ec; e_pc[k] = pc;
      e_st[k] = (k + 1 < n) ? stb[k + 1] : -1;
    end
  endtask

  task automatic run(input int carry);
    rst = 1'b0;
    inp = 16'(carry);
    @(posedge clk); #1;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 1);
    chk("rst_pv", peak_valid, 0);
    chk("rst_pu", pileup, 0);
    chk("rst_peak", peak, 0);
    chk("rst_ptime", peak_time, 0);
    chk("rst_evt", evt_count, 0);
    chk("rst_puc", pu_count, 0);
    rst = 1'b1;
    build_model();
    for (int k = 0; k < s.size(); k++) begin
      cyc = k;
      inp = 16'(s[k]);
      @(posedge clk); #1;
      chk("pv", peak_valid, e_pv[k]);
      chk("pu", pileup, e_pu[k]);
      chk("peak", peak, e_pk[k]);
      chk("ptime", peak_time, e_pt[k]);
      chk("evt", evt_count, e_ec[k]);
      chk("puc", pu_count, e_pc[k]);
      if (e_st[k] >= 0) begin
        chk("state", state, e_st[k]);
        chk("busy", busy, (e_st[k] != 1) ? 1 : 0);
      end
    end
  endtask

  task automatic gen_random();
    int kind, a1, a2, dp, ru, fd, v;
    s.delete();
    for (int k = 0; k < ARM_D; k++) add(int'($urandom_range(0, 3000)));
    while (s.size() < 360) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: for (int k = 0; k < int'($urandom_range(1, 8)); k++)
             add(int'($urandom_range(0, 760)) - 500);
        1: begin
          a1 = int'($urandom_range(150, 3000));
          ru = int'($urandom_range(1, 8));
          fd = int'($urandom_range(1, 8));
          for (int r = 1; r <= ru; r++) add(a1 * r / ru);
          for (int f = fd - 1; f >= 0; f--) add(a1 * f / fd);
        end
        2: begin
          a1 = int'($urandom_range(300, 2000));
          a2 = int'($urandom_range(300, 2000));
          dp = a1 - int'($urandom_range(0, 400));
          add(a1 / 2); add(a1); add(dp);
          add((dp + a2) / 2); add(a2); add(a2 / 2); add(0);
        end
        3: begin
          v = int'($urandom_range(201, 800));
          add(v, int'($urandom_range(30, 70)));
        end
        default: add(0, int'($urandom_range(1, 15)));
      endcase
    end
    add(0, 70);
  endtask

  initial begin
    rst = 1'b0;
    inp = '0;

    // Arm gating, clean pulse, threshold edges, double hump
    s.delete();
    add(1000, ARM_D);
    add(0, 3);
    for (int v = 0; v <= 1000; v += 100) add(v);
    for (int v = 900; v >= 0; v -= 100) add(v);
    add(0, 15);
    add(200); add(0); add(201); add(500); add(180); add(179);
    add(0, 15);
    add(0); add(200); add(400); add(600); add(800); add(700); add(600);
    add(500); add(600); add(700); add(800); add(900); add(700);
    add(500); add(300); add(100); add(0);
    add(0, 15);
    run(0);
    chk("A_peak", peak, 500);
    chk("A_ptime", peak_time, 1);
    chk("A_evt", evt_count, 2);
    chk("A_puc", pu_count, 1);

    // Overlength plateau, then retrigger on first idle sample
    s.delete();
    add(0, ARM_D + 1);
    add(500, 80);
    add(0, 15);
    run(0);
    chk("B_peak", peak, 500);
    chk("B_ptime", peak_time, 0);
    chk("B_evt", evt_count, 1);
    chk("B_puc", pu_count, 1);

    // Dead time, ending inside a pulse that the next reset cuts short
    s.delete();
    add(0, ARM_D + 2);
    add(300); add(1000); add(300); add(0);
    add(0, 2);
    add(300); add(600); add(300); add(0);
    add(0, 6);
    add(300); add(700); add(300); add(0);
    add(0, 15);
    add(300); add(500); add(700);
    run(0);
    chk("C_peak", peak, 700);
    chk("C_ptime", peak_time, 1);
    chk("C_evt", evt_count, 2);
    chk("C_puc", pu_count, 0);
    chk("C_state", state, 2);

    for (int r = 0; r < 6; r++) begin
      gen_random();
      run((r == 0) ? 700 : 0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
